cla_serial_add_ctrl: RTL

Sequencing controller that performs WIDTH-bit addition or subtraction by passing operands nibble by nibble through one internal 4-bit carry-look-ahead adder slice. The controller holds the running carry between nibbles and assembles the result. It sits between a requester using a start/done handshake and the shared 4-bit CLA datapath, so wide operands can be added without a wide adder.

---
 rtl/cla_serial_add_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/cla_serial_add_ctrl.sv
// rtl/cla_serial_add_ctrl.sv - nibble-serial add/subtract controller around a 4-bit CLA slice

module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [3:0] c;

  always_comb begin
    g = x & y;
    p = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end
endmodule

module cla_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb;
  logic             c;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_s;
  logic             nib_co;
  logic             last;

  assign last = (idx == IW'(N - 1));

  cla4 u_cla (
    .x  (opa[4*idx +: 4]),
    .y  (opb[4*idx +: 4]),
    .ci (c),
    .s  (nib_s),
    .co (nib_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is folded into the add path: latch ~b and force the carry-in to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      c        <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opa      <= a;
            opb      <= sub ? ~b : b;
            c        <= sub ? 1'b1 : cin;
            idx      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= nib_s;
          c               <= nib_co;
          if (last) begin
            // nib_s[3] is the result MSB being written this cycle
            cout     <= nib_co;
            overflow <= (opa[WIDTH-1] == opb[WIDTH-1]) && (nib_s[3] != opa[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
endmodule
